// File: rtl/nibble_add_seq_pkg.sv
// Shared definitions for the nibble-serial adder: slice width, FSM encodings
// and the counter-width helper.
package adder_defs;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < n) r = r + 1;
    end
    return r;
  endfunction

  // A single-nibble build still needs a 1-bit counter to hold its index.
  function automatic int cnt_width(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/fourbitFA.sv
// Existing 4-bit ripple-carry adder slice, reused one nibble per cycle by the
// serial controller.
module fourbitFA (
  output logic       cout,
  output logic [3:0] sumout,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin
);

  logic [4:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < 4; i++) begin : g_bit
    assign sumout[i] = a[i] ^ b[i] ^ c[i];
    assign c[i+1]    = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[4];

endmodule

// File: rtl/nibble_add_seq.sv
// Wide adder built from one shared 4-bit slice: operands are shifted through
// the slice LSB-nibble first, with the carry chained through a register.
module nibble_add_seq
  import adder_defs::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NIB_W*NIBBLES-1:0] a,
  input  logic [NIB_W*NIBBLES-1:0] b,
  input  logic                 cin,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NIB_W*NIBBLES-1:0] sum,
  output logic                 cout,
  output logic                 busy
);

  localparam int W  = NIB_W * NIBBLES;
  localparam int CW = cnt_width(NIBBLES);
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; ready never depends on valid, and the result stays put until taken.
  state_t          state;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic [W-1:0]    sum_q;
  logic            carry_q;
  logic [CW-1:0]   cnt;

  logic            slice_cout;
  logic [NIB_W-1:0] slice_sum;
  logic [W-1:0]    sum_next;

  fourbitFA u_slice (
    .cout   (slice_cout),
    .sumout (slice_sum),
    .a      (a_q[NIB_W-1:0]),
    .b      (b_q[NIB_W-1:0]),
    .cin    (carry_q)
  );

  // New nibble enters at the top so the LSB nibble lands at bit 0 after the last step.
  assign sum_next = (sum_q >> NIB_W) | (W'(slice_sum) << (W - NIB_W));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            cnt     <= '0;
            state   <= CALC;
          end
        end
        CALC: begin
          a_q     <= a_q >> NIB_W;
          b_q     <= b_q >> NIB_W;
          sum_q   <= sum_next;
          carry_q <= slice_cout;
          cnt     <= cnt + CW'(1);
          if (cnt == LAST) state <= DONE;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);
  assign busy      = (state == CALC) || (state == DONE);
  assign sum       = sum_q;
  assign cout      = carry_q;

endmodule

// File: tb/tb_nibble_add_seq.sv
// Directed bench for nibble_add_seq: default 4-nibble build plus a 1-nibble build.
module tb_nibble_add_seq;

  logic        clk;
  logic        rst;

  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        busy;

  logic        in_valid1;
  logic        in_ready1;
  logic [3:0]  a1;
  logic [3:0]  b1;
  logic        cin1;
  logic        out_valid1;
  logic        out_ready1;
  logic [3:0]  sum1;
  logic        cout1;
  logic        busy1;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  nibble_add_seq #(.NIBBLES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  nibble_add_seq #(.NIBBLES(1)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid1),
    .in_ready  (in_ready1),
    .a         (a1),
    .b         (b1),
    .cin       (cin1),
    .out_valid (out_valid1),
    .out_ready (out_ready1),
    .sum       (sum1),
    .cout      (cout1),
    .busy      (busy1)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  // Checker
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Drivers (called at #1 after a rising edge)
  task automatic send(input logic [15:0] ta, input logic [15:0] tb_v, input logic tc,
                      output int acc_cyc);
    int n;
    a = ta; b = tb_v; cin = tc; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    acc_cyc  = cyc;
    in_valid = 1'b0;
  endtask

  task automatic wait_result(output int lat);
    int n;
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!out_valid) check("result_timeout", 32'd0, 32'd1);
    lat = n;
  endtask

  task automatic run_vec(input string tag, input logic [15:0] ta, input logic [15:0] tb_v,
                         input logic tc, input logic [15:0] exp_sum, input logic exp_cout);
    int acc, lat;
    send(ta, tb_v, tc, acc);
    wait_result(lat);
    check({tag, "_lat"}, lat, 4);
    check({tag, "_sum"}, sum, exp_sum);
    check({tag, "_cout"}, cout, exp_cout);
    @(posedge clk); #1;
  endtask

  initial begin
    int acc, prev_acc, lat;
    logic [15:0] ra, rb;
    logic        rc;
    logic [16:0] gold;

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;
    in_valid1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0; out_ready1 = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_busy", busy, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1 check("idle_in_ready", in_ready, 1);

    // Basic directed vectors
    run_vec("v0606", 16'h0606, 16'h0606, 1'b0, 16'h0C0C, 1'b0);
    run_vec("vffff", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
    run_vec("vcin",  16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0);
    run_vec("vmax",  16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1);

    // Backpressure: result held, new request ignored until IDLE is re-entered
    out_ready = 1'b0;
    send(16'hABCD, 16'h1111, 1'b0, acc);
    wait_result(lat);
    check("bp_lat", lat, 4);
    a = 16'h2222; b = 16'h3333; cin = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_sum", sum, 16'hBCDE);
      check("bp_cout", cout, 0);
      check("bp_in_ready", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_released_valid", out_valid, 0);
    check("bp_released_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_accept_busy", busy, 1);
    wait_result(lat);
    check("bp_next_lat", lat, 4);
    check("bp_next_sum", sum, 16'h5556);
    check("bp_next_cout", cout, 0);
    out_ready = 1'b1;
    @(posedge clk); #1;

    // Reset during the second CALC cycle aborts the request
    send(16'h0606, 16'h0606, 1'b0, acc);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("abort_in_ready", in_ready, 0);
    check("abort_out_valid", out_valid, 0);
    check("abort_sum", sum, 0);
    check("abort_cout", cout, 0);
    check("abort_busy", busy, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("abort_no_result", out_valid, 0);
    end
    run_vec("post_abort", 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0);

    // Back-to-back random requests with out_ready held high
    prev_acc = 0;
    for (int i = 0; i < 200; i++) begin
      ra = 16'($urandom_range(0, 16'hFFFF));
      rb = 16'($urandom_range(0, 16'hFFFF));
      rc = 1'($urandom_range(0, 1));
      gold = {1'b0, ra} + {1'b0, rb} + {16'd0, rc};
      send(ra, rb, rc, acc);
      if (i > 0) check("b2b_spacing", acc - prev_acc, 6);
      prev_acc = acc;
      wait_result(lat);
      check("b2b_sum", sum, gold[15:0]);
      check("b2b_cout", cout, gold[16]);
    end
    @(posedge clk); #1;

    // Single-nibble build: result one cycle after accept
    check("n1_in_ready", in_ready1, 1);
    a1 = 4'hF; b1 = 4'h1; cin1 = 1'b1; in_valid1 = 1'b1;
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    check("n1_busy", busy1, 1);
    check("n1_early_valid", out_valid1, 0);
    @(posedge clk); #1;
    check("n1_out_valid", out_valid1, 1);
    check("n1_sum", sum1, 4'h1);
    check("n1_cout", cout1, 1);
    @(posedge clk); #1;
    check("n1_back_idle", in_ready1, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/nibble_add_seq.md
# nibble_add_seq

Multi-cycle wide-operand adder controller. Accepts a (4·NIBBLES)-bit add request through a valid/ready handshake, then drives a single shared `fourbitFA` slice one nibble per cycle, least-significant nibble first, chaining the carry through a register. Returns the full sum and carry-out through a second valid/ready handshake. It sits between any requester needing wide additions and the existing 4-bit ripple adder, so wide operands never need a wide adder in hardware.

## Interface
Parameters:
- `NIBBLES`, default 4: number of 4-bit slices. Operand width `W = 4*NIBBLES`. Legal range is 1..16.

Ports:
- `clk`  in  1  single clock, rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  request present.
- `in_ready`  out  1  controller can accept a request.
- `a`  in  W  operand A.
- `b`  in  W  operand B.
- `cin`  in  1  carry-in to the least-significant nibble.
- `out_valid`  out  1  result present.
- `out_ready`  in  1  consumer accepts the result.
- `sum`  out  W  result, `(a+b+cin) mod 2^W`.
- `cout`  out  1  carry out of the most-significant nibble.
- `busy`  out  1  high in CALC or DONE.

## Operation
- FSM states:
  - IDLE: `in_ready=1`.
  - CALC: one nibble per cycle.
  - DONE: `out_valid=1`.
- IDLE → CALC on `in_valid && in_ready`. On that edge:
  - latch `a` and `b` into operand shift registers;
  - set carry register to `cin`;
  - set nibble counter to 0.
- Each CALC cycle:
  - the slice adds the low nibble of each operand register plus the carry register;
  - the slice sum nibble is shifted into the top of the sum register (right shift by 4);
  - the operand registers shift right by 4;
  - carry register takes the slice `cout`;
  - counter increments.
- CALC → DONE on the edge where the counter reaches NIBBLES-1. That same edge performs the last nibble's add.
- In DONE:
  - `sum` and `cout` are register outputs and stay stable;
  - DONE → IDLE on `out_ready`.
- `in_ready` is combinational from state: 1 only in IDLE and while `rst` is low.
- `out_valid` is 1 only in DONE.
- Overflow is not flagged separately. `cout` carries it, and `sum` wraps modulo 2^W.
- `in_valid` outside IDLE is ignored. Operands need only be stable in the accept cycle.
- Reset values: state IDLE, `in_ready` 0 while `rst` is high, `out_valid` 0, `sum` 0, `cout` 0, `busy` 0, all internal registers 0.
- Reset asserted mid-CALC or in DONE aborts the operation. No result is ever presented for the aborted request.

## Timing
- Accept on edge k. Nibble i is computed at edge k+1+i. DONE is entered at edge k+NIBBLES, and `out_valid` is high in the following cycle.
- Latency from accept edge to `out_valid` is NIBBLES cycles.
- With `out_ready` held high, DONE lasts 1 cycle. The next accept is possible at edge k+NIBBLES+2, giving a minimum period of NIBBLES+2 cycles (6 at default).
- Backpressure: `out_ready` low holds DONE indefinitely, with `sum`/`cout` unchanged and `in_ready` 0.
- There is no same-cycle result-to-accept bypass. `in_valid` asserted in DONE is taken only after IDLE is re-entered.
- NIBBLES=1: CALC lasts exactly one cycle. Behaviour is otherwise identical.

## Structure
- Shared package/header `adder_defs`:
  - state encodings IDLE/CALC/DONE (2-bit);
  - nibble width constant 4;
  - counter width function `clog2(NIBBLES)`.
- One sub-module: an instance of the existing `fourbitFA`. Port order is `(cout, sumout, a, b, cin)`, driven from the low nibbles and the carry register.
- The controller holds the FSM, counter, operand shift registers, sum shift register and carry register. No arithmetic is done outside the slice.

## Test plan
- `a=0x0606`, `b=0x0606`, `cin=0` → after 4 cycles `out_valid=1`, `sum=0x0C0C`, `cout=0`.
- `a=0xFFFF`, `b=0x0001`, `cin=0` → `sum=0x0000`, `cout=1` (carry ripples through all four nibble cycles). Also `a=b=0x0000`, `cin=1` → `sum=0x0001`, `cout=0`.
- Result held with `out_ready=0` for 10 cycles, with `in_valid=1` and new operands driven → `sum`/`cout` stable, `in_ready=0`, new request accepted only after `out_ready` pulses and IDLE is re-entered.
- `rst` pulsed at the second CALC cycle → `out_valid` stays 0, all outputs 0. The next request (`0x1234+0x4321`, `cin=1`) returns `0x5556`, `cout=0`.
- 200 back-to-back random requests with `out_ready=1` → every result equals golden `a+b+cin`, and accept edges are spaced exactly 6 cycles.
- NIBBLES=1 build, `a=0xF`, `b=0x1`, `cin=1` → `sum=0x1`, `cout=1`, one cycle after accept.
